// File: rtl/mdu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mdu_ctrl_pkg
// Description : Shared definitions for the multiply/divide sequencer.
//               Provides the E-stage op codes, the default latencies, the
//               sequencer state encoding and the op-classification helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package mdu_ctrl_pkg;

    // E-stage md op codes; code 7 is reserved and behaves as NONE
    localparam logic [2:0] c_MD_NONE  = 3'd0;
    localparam logic [2:0] c_MD_MULT  = 3'd1;
    localparam logic [2:0] c_MD_MULTU = 3'd2;
    localparam logic [2:0] c_MD_DIV   = 3'd3;
    localparam logic [2:0] c_MD_DIVU  = 3'd4;
    localparam logic [2:0] c_MD_MTHI  = 3'd5;
    localparam logic [2:0] c_MD_MTLO  = 3'd6;

    // Default busy latencies
    localparam int c_MUL_LAT_DEF = 5;
    localparam int c_DIV_LAT_DEF = 10;

    // Sequencer state encoding
    localparam logic c_ST_IDLE = 1'b0;
    localparam logic c_ST_BUSY = 1'b1;

    function automatic logic f_is_mul(input logic [2:0] op);
        return (op == c_MD_MULT) || (op == c_MD_MULTU);
    endfunction

    function automatic logic f_is_div(input logic [2:0] op);
        return (op == c_MD_DIV) || (op == c_MD_DIVU);
    endfunction

endpackage : mdu_ctrl_pkg
`default_nettype wire

// File: rtl/mdu_arith.sv
`default_nettype none
// ============================================================================
// Module      : mdu_arith
// Description : Combinational multiply/divide datapath.
//               Computes the HI/LO result for MULT/MULTU/DIV/DIVU and flags a
//               divide by zero. Results for non-arith ops are zero.
// Ports       : i_op      [2:0]  md op code
//               i_a       [31:0] operand A (multiplicand / dividend)
//               i_b       [31:0] operand B (multiplier / divisor)
//               o_hi_res  [31:0] product high word / remainder
//               o_lo_res  [31:0] product low word / quotient
//               o_div0           divide op with a zero divisor
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_arith
    import mdu_ctrl_pkg::*;
(
    input  logic [2:0]  i_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [31:0] o_hi_res,
    output logic [31:0] o_lo_res,
    output logic        o_div0
);

    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    logic        w_b_zero;
    logic        w_ovf;
    logic [31:0] w_div_bu;
    logic [31:0] w_div_bs;
    logic [31:0] w_quo_s;
    logic [31:0] w_rem_s;
    logic [31:0] w_quo_u;
    logic [31:0] w_rem_u;

    assign w_prod_s = $signed({{32{i_a[31]}}, i_a}) * $signed({{32{i_b[31]}}, i_b});
    assign w_prod_u = {32'd0, i_a} * {32'd0, i_b};

    assign w_b_zero = (i_b == 32'd0);
    assign w_ovf    = (i_a == 32'h8000_0000) && (i_b == 32'hFFFF_FFFF);

    // Divisors are steered away from zero and, for the signed case, away from
    // the 0x80000000 / -1 overflow: dividing by 1 there yields exactly the
    // required quotient 0x80000000 with remainder 0.
    assign w_div_bu = w_b_zero ? 32'd1 : i_b;
    assign w_div_bs = (w_b_zero || w_ovf) ? 32'd1 : i_b;

    assign w_quo_s = $signed(i_a) / $signed(w_div_bs);
    assign w_rem_s = $signed(i_a) % $signed(w_div_bs);
    assign w_quo_u = i_a / w_div_bu;
    assign w_rem_u = i_a % w_div_bu;

    assign o_div0 = f_is_div(i_op) && w_b_zero;

    always_comb begin
        o_hi_res = 32'd0;
        o_lo_res = 32'd0;
        case (i_op)
            c_MD_MULT: begin
                o_hi_res = w_prod_s[63:32];
                o_lo_res = w_prod_s[31:0];
            end
            c_MD_MULTU: begin
                o_hi_res = w_prod_u[63:32];
                o_lo_res = w_prod_u[31:0];
            end
            c_MD_DIV: begin
                o_hi_res = w_rem_s;
                o_lo_res = w_quo_s;
            end
            c_MD_DIVU: begin
                o_hi_res = w_rem_u;
                o_lo_res = w_quo_u;
            end
            default: begin
                o_hi_res = 32'd0;
                o_lo_res = 32'd0;
            end
        endcase
    end

endmodule : mdu_arith
`default_nettype wire

// File: rtl/mdu_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mdu_ctrl
// Description : Multi-cycle multiply/divide sequencer for the 5-stage pipeline.
//               Owns HI/LO, models operation latency with a countdown and
//               drives the D-stage stall while an operation is in flight.
// Ports       : clk            pipeline clock, rising edge
//               reset          synchronous active-high reset
//               md_op_e  [2:0] E-stage md op
//               rs_e    [31:0] operand A / MTHI,MTLO source
//               rt_e    [31:0] operand B
//               md_use_d       D-stage instruction uses the MDU
//               start          arith op accepted this cycle (comb)
//               busy           operation in flight (registered)
//               stall_md       D-stage stall request (comb)
//               hi      [31:0] committed HI
//               lo      [31:0] committed LO
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int MUL_LAT = c_MUL_LAT_DEF,
    parameter int DIV_LAT = c_DIV_LAT_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  md_op_e,
    input  logic [31:0] rs_e,
    input  logic [31:0] rt_e,
    input  logic        md_use_d,
    output logic        start,
    output logic        busy,
    output logic        stall_md,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int c_MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int c_CNT_W   = $clog2(c_MAX_LAT + 1);

    logic               r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [31:0]        r_hi_nxt;
    logic [31:0]        r_lo_nxt;
    logic               r_wr_nxt;   // pending result is to be committed
    logic [31:0]        r_hi;
    logic [31:0]        r_lo;

    logic [31:0]        w_hi_res;
    logic [31:0]        w_lo_res;
    logic               w_div0;
    logic               w_idle;
    logic [c_CNT_W-1:0] w_lat;

    mdu_arith u_arith (
        .i_op     (md_op_e),
        .i_a      (rs_e),
        .i_b      (rt_e),
        .o_hi_res (w_hi_res),
        .o_lo_res (w_lo_res),
        .o_div0   (w_div0)
    );

    assign w_idle   = (r_state == c_ST_IDLE);
    assign start    = w_idle && (f_is_mul(md_op_e) || f_is_div(md_op_e));
    assign busy     = (r_state == c_ST_BUSY);
    assign stall_md = md_use_d && (start || busy);
    assign hi       = r_hi;
    assign lo       = r_lo;

    assign w_lat = f_is_mul(md_op_e) ? c_CNT_W'(MUL_LAT) : c_CNT_W'(DIV_LAT);

    // The result is computed in the start cycle and parked in the pending
    // registers; the countdown only models latency. The counter holds the
    // number of busy cycles still to run, so the commit edge is the one
    // where it reads 1.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= c_ST_IDLE;
            r_cnt    <= '0;
            r_hi_nxt <= 32'd0;
            r_lo_nxt <= 32'd0;
            r_wr_nxt <= 1'b0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        r_state  <= c_ST_BUSY;
                        r_cnt    <= w_lat;
                        r_hi_nxt <= w_hi_res;
                        r_lo_nxt <= w_lo_res;
                        r_wr_nxt <= ~w_div0;
                    end else if (md_op_e == c_MD_MTHI) begin
                        r_hi <= rs_e;
                    end else if (md_op_e == c_MD_MTLO) begin
                        r_lo <= rs_e;
                    end
                end
                c_ST_BUSY: begin
                    r_cnt <= r_cnt - c_CNT_W'(1);
                    if (r_cnt == c_CNT_W'(1)) begin
                        r_state  <= c_ST_IDLE;
                        r_wr_nxt <= 1'b0;
                        if (r_wr_nxt) begin
                            r_hi <= r_hi_nxt;
                            r_lo <= r_lo_nxt;
                        end
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

endmodule : mdu_ctrl
`default_nettype wire

// File: tb/tb_mdu_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mdu_ctrl
// Description : Self-checking testbench for mdu_ctrl. Directed vector table,
//               randomized ops against a 64-bit arithmetic reference model,
//               and hand-written reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mdu_ctrl;

    localparam int MUL_LAT = 5;
    localparam int DIV_LAT = 10;

    localparam logic [2:0] OP_NONE  = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;
    localparam logic [2:0] OP_RSVD  = 3'd7;

    logic        clk;
    logic        reset;
    logic [2:0]  md_op_e;
    logic [31:0] rs_e;
    logic [31:0] rt_e;
    logic        md_use_d;
    logic        start;
    logic        busy;
    logic        stall_md;
    logic [31:0] hi;
    logic [31:0] lo;

    int          checks;
    int          errors;
    logic        allow_viol;
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    mdu_ctrl #(
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .md_op_e  (md_op_e),
        .rs_e     (rs_e),
        .rt_e     (rt_e),
        .md_use_d (md_use_d),
        .start    (start),
        .busy     (busy),
        .stall_md (stall_md),
        .hi       (hi),
        .lo       (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Any md op offered while busy is a protocol violation unless deliberate.
    always @(negedge clk) begin
        assert (reset || allow_viol || !busy || (md_op_e == OP_NONE) || (md_op_e == OP_RSVD))
        else begin
            errors++;
            $display("FAIL protocol: md op %0d presented while busy", md_op_e);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference model: plain 64-bit arithmetic on sign/zero-extended operands.
    function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] ohi, input logic [31:0] olo,
                                  output logic [31:0] nhi, output logic [31:0] nlo);
        longint      sa;
        longint      sb;
        longint      sq;
        longint      sr;
        logic [63:0] p;
        logic [63:0] ua;
        logic [63:0] ub;
        sa  = {{32{a[31]}}, a};
        sb  = {{32{b[31]}}, b};
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        nhi = ohi;
        nlo = olo;
        case (op)
            OP_MULT:  begin p = sa * sb; nhi = p[63:32]; nlo = p[31:0]; end
            OP_MULTU: begin p = ua * ub; nhi = p[63:32]; nlo = p[31:0]; end
            OP_DIV: if (b != 32'd0) begin
                sq = sa / sb; sr = sa % sb; nlo = sq[31:0]; nhi = sr[31:0];
            end
            OP_DIVU: if (b != 32'd0) begin nlo = a / b; nhi = a % b; end
            OP_MTHI: nhi = a;
            OP_MTLO: nlo = a;
            default: ;
        endcase
    endfunction

    // Present one op in cycle 0 (inputs change 1 time unit after posedge,
    // outputs sampled 1 unit later), then follow it to completion.
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic use_d, input logic intrude,
                         input logic [31:0] eh, input logic [31:0] el);
        bit arith;
        int lat;
        int stalls;
        arith  = (op >= OP_MULT) && (op <= OP_DIVU);
        lat    = (op == OP_MULT || op == OP_MULTU) ? MUL_LAT : DIV_LAT;
        md_op_e = op; rs_e = a; rt_e = b; md_use_d = use_d;
        #1;
        chk("start_c0", start, arith);
        chk("busy_c0", busy, 0);
        chk("stall_c0", stall_md, use_d & arith);
        stalls = stall_md;
        @(posedge clk); #1;
        md_op_e = OP_NONE; rs_e = $urandom; rt_e = $urandom;
        if (arith) begin
            for (int k = 1; k <= lat; k++) begin
                if (intrude && k == 2) begin
                    allow_viol = 1'b1;
                    md_op_e = OP_MULT; rs_e = 32'd1; rt_e = 32'd1;
                end
                #1;
                chk("busy_run", busy, 1);
                chk("start_run", start, 0);
                chk("hi_hold", hi, m_hi);
                chk("lo_hold", lo, m_lo);
                stalls += stall_md;
                @(posedge clk); #1;
                md_op_e = OP_NONE;
                allow_viol = 1'b0;
            end
        end
        #1;
        chk("busy_end", busy, 0);
        chk("hi_res", hi, eh);
        chk("lo_res", lo, el);
        chk("stall_end", stall_md, 0);
        if (use_d) chk("stall_cnt", stalls, arith ? lat + 1 : 0);
        m_hi = eh;
        m_lo = el;
        md_use_d = 1'b0;
    endtask

    // Start an op, raise reset during cycle k (0 = the start cycle itself)
    // and confirm the pending result never lands.
    task automatic reset_during(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                input int k);
        do_op(OP_MTHI, 32'hAAAA_5555, 32'd0, 1'b0, 1'b0, 32'hAAAA_5555, m_lo);
        do_op(OP_MTLO, 32'h1234_0FED, 32'd0, 1'b0, 1'b0, 32'hAAAA_5555, 32'h1234_0FED);
        md_op_e = op; rs_e = a; rt_e = b;
        if (k == 0) reset = 1'b1;
        for (int i = 1; i <= k; i++) begin
            @(posedge clk); #1;
            md_op_e = OP_NONE;
            if (i == k) reset = 1'b1;
        end
        @(posedge clk); #1;
        reset = 1'b0;
        md_op_e = OP_NONE;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        for (int i = 0; i < DIV_LAT + 2; i++) begin
            @(posedge clk); #2;
            chk("rst_busy_after", busy, 0);
            chk("rst_hi_after", {hi | lo}, 0);
        end
        m_hi = 32'd0;
        m_lo = 32'd0;
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        use_d;
        logic        intrude;
        logic [31:0] eh;
        logic [31:0] el;
    } vec_t;

    vec_t vecs[12];

    initial begin
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] eh;
        logic [31:0] el;
        int          sel;

        checks = 0; errors = 0; allow_viol = 1'b0;
        m_hi = 32'd0; m_lo = 32'd0;
        reset = 1'b1; md_op_e = OP_NONE; rs_e = 32'd0; rt_e = 32'd0; md_use_d = 1'b0;

        vecs[0]  = '{OP_MULT,  32'h0000_0003, 32'hFFFF_FFFE, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFA};
        vecs[1]  = '{OP_MULTU, 32'h0000_0003, 32'hFFFF_FFFE, 1'b0, 1'b0, 32'h0000_0002, 32'hFFFF_FFFA};
        vecs[2]  = '{OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3]  = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0000_0000, 32'h8000_0000};
        vecs[4]  = '{OP_MTLO,  32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000};
        vecs[5]  = '{OP_MTHI,  32'h1234_5678, 32'h0000_0000, 1'b1, 1'b0, 32'h1234_5678, 32'h0000_0000};
        vecs[6]  = '{OP_DIVU,  32'h0000_0055, 32'h0000_0000, 1'b0, 1'b0, 32'h1234_5678, 32'h0000_0000};
        vecs[7]  = '{OP_RSVD,  32'hDEAD_BEEF, 32'h0000_0001, 1'b1, 1'b0, 32'h1234_5678, 32'h0000_0000};
        vecs[8]  = '{OP_MULT,  32'h0000_0007, 32'h0000_0006, 1'b1, 1'b0, 32'h0000_0000, 32'h0000_002A};
        vecs[9]  = '{OP_MULT,  32'hFFFF_0000, 32'h0001_0000, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[10] = '{OP_DIVU,  32'hFFFF_FFFF, 32'h0000_0010, 1'b0, 1'b0, 32'h0000_000F, 32'h0FFF_FFFF};
        vecs[11] = '{OP_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 1'b1, 1'b0, 32'h0000_0001, 32'hFFFF_FFFD};

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("reset_busy", busy, 0);
        chk("reset_hi", hi, 0);
        chk("reset_lo", lo, 0);
        chk("reset_start", start, 0);

        for (int i = 0; i < 12; i++) begin
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].use_d, vecs[i].intrude,
                  vecs[i].eh, vecs[i].el);
        end

        for (int n = 0; n < 60; n++) begin
            op  = 3'($urandom_range(1, 6));
            a   = $urandom;
            b   = $urandom;
            sel = $urandom_range(0, 7);
            if (sel == 0) b = 32'd0;
            else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            else if (sel == 2) b = 32'($urandom_range(1, 9));
            else if (sel == 3) b = -32'($urandom_range(1, 9));
            model(op, a, b, m_hi, m_lo, eh, el);
            do_op(op, a, b, 1'($urandom_range(0, 1)), (sel == 4), eh, el);
        end

        reset_during(OP_DIV,  32'd100, 32'd7, 3);
        reset_during(OP_MULT, 32'd2,   32'd3, MUL_LAT);
        reset_during(OP_MULT, 32'd5,   32'd5, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_mdu_ctrl
`default_nettype wire
